// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the ALU arbiter slice:
//   - ALU control encodings (ADD/SUB/AND/ORR)
//   - FSM state encoding for the arbiter sequencer
//   - bit positions of the {N, Z, C, V} flag nibble and a packing helper
// -----------------------------------------------------------------------------
package alu_arbiter_pkg;

  localparam int FLAGS_W = 4;

  // ALU control encodings, as understood by the shared ALU.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Sequencer states.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Flag nibble layout: {Negative, Zero, Carry, Overflow}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [1:0] state_t;

  // Packs the individual ALU flag wires into the response flag nibble.
  function automatic logic [FLAGS_W-1:0] pack_flags(input logic n,
                                                    input logic z,
                                                    input logic c,
                                                    input logic v);
    logic [FLAGS_W-1:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Request/response bundle between two requesters and the ALU arbiter.
//   req0_* / req1_* : valid/ready request channel carrying SrcA, SrcB, control
//   rsp0_* / rsp1_* : valid/ready response channel, one per requester
//   rsp_result      : shared registered result bus
//   rsp_flags       : shared registered {N, Z, C, V}
// Modports:
//   master : the requester side (drives requests, consumes responses)
//   slave  : the arbiter side
// -----------------------------------------------------------------------------
interface alu_arbiter_if
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 2
);

  logic               req0_valid;
  logic               req0_ready;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req0_b;
  logic [CTRL_W-1:0]  req0_ctrl;

  logic               req1_valid;
  logic               req1_ready;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req1_b;
  logic [CTRL_W-1:0]  req1_ctrl;

  logic               rsp0_valid;
  logic               rsp0_ready;
  logic               rsp1_valid;
  logic               rsp1_ready;
  logic [WIDTH-1:0]   rsp_result;
  logic [FLAGS_W-1:0] rsp_flags;

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl,
    output req1_valid, req1_a, req1_b, req1_ctrl,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_flags
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl,
    input  req1_valid, req1_a, req1_b, req1_ctrl,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_flags
  );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin grant.
//   valid[1:0]  : pending requests
//   last_grant  : index of the requester granted most recently
//   grant[1:0]  : one-hot grant (all zero when nothing is valid)
// A lone valid requester always wins; on contention the requester that was
// not granted last time wins, so neither side can be starved.
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between two requesters.
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   bus (slave modport)   : request/response handshakes for both requesters
//   alu_a/alu_b/alu_ctrl  : registered operands driven into the external ALU
//   alu_result, alu_*     : combinational result and flags back from the ALU
//   busy                  : high whenever an operation is in flight
// Sequence per operation: IDLE (arbitrate, latch operands) -> EXEC (ALU
// settles on registered operands, result/flags captured) -> RESP (hold the
// response until the owning requester takes it).
// -----------------------------------------------------------------------------
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  alu_arbiter_if.slave      bus,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  input  logic              alu_negative,
  input  logic              alu_overflow,
  input  logic              alu_carry,
  output logic              busy
);

  state_t             state;
  logic               owner;
  logic               last_grant;
  logic [1:0]         req_valid;
  logic [1:0]         grant;
  logic               accept;
  logic               rsp_hs;

  logic [WIDTH-1:0]   opa_p0;
  logic [WIDTH-1:0]   opb_p0;
  logic [CTRL_W-1:0]  ctrl_p0;

  logic [WIDTH-1:0]   res_p1;
  logic [FLAGS_W-1:0] flags_p1;
  logic [1:0]         vld_p1;

  assign req_valid = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_arb (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Readies are only offered in IDLE, so a requester waiting behind an
  // outstanding response is simply held off until the sequencer frees up.
  assign accept         = (state == IDLE) && (grant != 2'b00);
  assign bus.req0_ready = (state == IDLE) && grant[0];
  assign bus.req1_ready = (state == IDLE) && grant[1];

  assign rsp_hs = (state == RESP) && (owner ? bus.rsp1_ready : bus.rsp0_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      opa_p0     <= '0;
      opb_p0     <= '0;
      ctrl_p0    <= '0;
      res_p1     <= '0;
      flags_p1   <= '0;
      vld_p1     <= 2'b00;
    end else begin
      case (state)
        // Stage p0: operand capture on the accepting edge.
        IDLE: begin
          if (accept) begin
            opa_p0     <= grant[1] ? bus.req1_a    : bus.req0_a;
            opb_p0     <= grant[1] ? bus.req1_b    : bus.req0_b;
            ctrl_p0    <= grant[1] ? bus.req1_ctrl : bus.req0_ctrl;
            owner      <= grant[1];
            last_grant <= grant[1];
            state      <= EXEC;
          end
        end
        // Stage p1: ALU output captured into the response registers.
        EXEC: begin
          res_p1   <= alu_result;
          flags_p1 <= pack_flags(alu_negative, alu_zero, alu_carry, alu_overflow);
          vld_p1   <= owner ? 2'b10 : 2'b01;
          state    <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            vld_p1 <= 2'b00;
            state  <= IDLE;
          end
        end
        default: begin
          vld_p1 <= 2'b00;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign alu_a    = opa_p0;
  assign alu_b    = opb_p0;
  assign alu_ctrl = ctrl_p0;

  assign bus.rsp0_valid = vld_p1[0];
  assign bus.rsp1_valid = vld_p1[1];
  assign bus.rsp_result = res_p1;
  assign bus.rsp_flags  = flags_p1;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [1:0]  alu_ctrl;
  logic        alu_zero, alu_negative, alu_overflow, alu_carry;
  logic        busy;

  alu_arbiter_if #(.WIDTH(32), .CTRL_W(2)) bus ();

  alu_arbiter #(.WIDTH(32), .CTRL_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .alu_overflow (alu_overflow),
    .alu_carry    (alu_carry),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // The shared ALU (adder with inverted-B subtract, AND/ORR on ctrl[1]).
  logic [32:0] sum33;
  logic [31:0] bsel;
  always_comb begin
    bsel  = alu_ctrl[0] ? ~alu_b : alu_b;
    sum33 = {1'b0, alu_a} + {1'b0, bsel} + {32'b0, alu_ctrl[0]};
    if (alu_ctrl[1]) alu_result = alu_ctrl[0] ? (alu_a | alu_b) : (alu_a & alu_b);
    else             alu_result = sum33[31:0];
    alu_carry    = ~alu_ctrl[1] & sum33[32];
    alu_overflow = ~alu_ctrl[1] & ~(alu_a[31] ^ alu_b[31] ^ alu_ctrl[0]) & (alu_a[31] ^ sum33[31]);
    alu_zero     = (alu_result == 32'd0);
    alu_negative = alu_result[31];
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        owner;
    logic [31:0] res;
    logic [3:0]  flags;
    int          acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          grant_log[$];
  int          cyc = 0;
  bit          model_last = 1'b1;
  logic [31:0] last_res = '0;
  logic [3:0]  last_flags = '0;
  int          rsp_count = 0;
  int          rsp_seen0 = 0;
  bit          prev_v0 = 0, prev_v1 = 0;
  logic [31:0] prev_res = '0;
  logic [3:0]  prev_flags = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: arithmetic from the operation's definition using wide integers.
  function automatic void ref_calc(input logic [31:0] a, input logic [31:0] b,
                                   input logic [1:0] ctrl,
                                   output logic [31:0] r, output logic [3:0] f);
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    logic signed [31:0] sa32 = a;
    logic signed [31:0] sb32 = b;
    longint sa = sa32;
    longint sb = sb32;
    longint sr;
    bit c = 0, v = 0;
    r = '0;
    case (ctrl)
      ALU_ADD: begin
        r = a + b; c = (ua + ub) > 64'hFFFF_FFFF;
        sr = sa + sb; v = (sr > SMAX) || (sr < SMIN);
      end
      ALU_SUB: begin
        r = a - b; c = (ua >= ub);
        sr = sa - sb; v = (sr > SMAX) || (sr < SMIN);
      end
      ALU_AND: r = a & b;
      default: r = a | b;
    endcase
    f = {r[31], (r == 32'd0), c, v};
  endfunction

  task automatic on_accept(input bit port, input bit v0, input bit v1,
                           input logic [31:0] a, input logic [31:0] b, input logic [1:0] ctrl);
    exp_t e;
    bit   exp_owner;
    exp_owner = (v0 && v1) ? !model_last : v1;
    chk("grant_owner", port, exp_owner);
    e.owner   = port;
    ref_calc(a, b, ctrl, e.res, e.flags);
    e.acc_cyc = cyc;
    exp_q.push_back(e);
    grant_log.push_back(port);
    model_last = port;
  endtask

  task automatic on_rsp(input bit port, input bit v, input bit rdy, input bit pv);
    exp_t e;
    if (!v) return;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_rsp port=%0d actual=valid required=idle", port);
      return;
    end
    e = exp_q[0];
    chk("rsp_owner", port, e.owner);
    if (!pv) chk("rsp_latency", cyc - e.acc_cyc, 2);
    else begin
      chk("hold_result", bus.rsp_result, prev_res);
      chk("hold_flags", bus.rsp_flags, prev_flags);
    end
    if (rdy) begin
      chk("rsp_result", bus.rsp_result, e.res);
      chk("rsp_flags", bus.rsp_flags, e.flags);
      last_res   = bus.rsp_result;
      last_flags = bus.rsp_flags;
      void'(exp_q.pop_front());
      rsp_count++;
      if (port == 1'b0) rsp_seen0++;
    end
  endtask

  // Monitor / scoreboard: samples on the falling edge, i.e. the values the
  // DUT and bench present to the next rising edge.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
      model_last = 1'b1;
      prev_v0 = 0;
      prev_v1 = 0;
    end else begin
      chk("ready_onehot", bus.req0_ready & bus.req1_ready, 0);
      chk("rspvalid_onehot", bus.rsp0_valid & bus.rsp1_valid, 0);
      if (bus.req0_valid && bus.req0_ready)
        on_accept(1'b0, bus.req0_valid, bus.req1_valid, bus.req0_a, bus.req0_b, bus.req0_ctrl);
      else if (bus.req1_valid && bus.req1_ready)
        on_accept(1'b1, bus.req0_valid, bus.req1_valid, bus.req1_a, bus.req1_b, bus.req1_ctrl);
      on_rsp(1'b0, bus.rsp0_valid, bus.rsp0_ready, prev_v0);
      on_rsp(1'b1, bus.rsp1_valid, bus.rsp1_ready, prev_v1);
      prev_v0    = bus.rsp0_valid;
      prev_v1    = bus.rsp1_valid;
      prev_res   = bus.rsp_result;
      prev_flags = bus.rsp_flags;
    end
  end

  task automatic send(input int port, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] ctrl, output int waited);
    bit done = 0;
    waited = 0;
    if (port == 0) begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_ctrl = ctrl;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_ctrl = ctrl;
    end
    while (!done && waited < 200) begin
      @(negedge clk);
      if ((port == 0 && bus.req0_ready) || (port == 1 && bus.req1_ready)) done = 1;
      else waited++;
    end
    @(posedge clk); #1;
    if (port == 0) bus.req0_valid = 1'b0;
    else           bus.req1_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout port=%0d actual=%0d cycles required=accept", port, waited);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, (exp_q.size() == 0 && !busy) ? 1 : 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n, base, base0;
    int exp_order[4];
    bit d0, d1;
    exp_order = '{0, 1, 0, 1};
    bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_ctrl = '0;
    bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_ctrl = '0;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_req1_ready", bus.req1_ready, 0);
    chk("rst_rsp0_valid", bus.rsp0_valid, 0);
    chk("rst_rsp1_valid", bus.rsp1_valid, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_rsp_flags", bus.rsp_flags, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_busy", busy, 0);
    tick(); reset = 0;

    // Single request, ADD
    send(0, 32'd4, 32'd5, ALU_ADD, w);
    chk("t1_accept_wait", w, 0);
    drain("t1_drain");
    chk("t1_result", last_res, 32'd9);
    chk("t1_flags", last_flags, 4'b0000);

    // Subtract with negative result from requester 1
    base0 = rsp_seen0;
    send(1, 32'd4, 32'd5, ALU_SUB, w);
    drain("t2_drain");
    chk("t2_result", last_res, 32'hFFFF_FFFF);
    chk("t2_flags", last_flags, 4'b1000);
    chk("t2_no_rsp0", rsp_seen0 - base0, 0);

    // Contention out of reset
    bus.req0_a = 32'hF0F0_F0F0; bus.req0_b = 32'h0FF0_0FF0; bus.req0_ctrl = ALU_AND;
    bus.req1_a = 32'hF0F0_F0F0; bus.req1_b = 32'h0FF0_0FF0; bus.req1_ctrl = ALU_AND;
    reset = 1; bus.req0_valid = 1; bus.req1_valid = 1;
    tick(); tick();
    reset = 0;
    grant_log.delete();
    n = 0;
    while (grant_log.size() < 4 && n < 100) begin tick(); n++; end
    bus.req0_valid = 0; bus.req1_valid = 0;
    drain("t3_drain");
    if (grant_log.size() < 4) begin
      checks++; errors++;
      $display("FAIL t3_grants actual=%0d grants required=4", grant_log.size());
    end else begin
      for (int i = 0; i < 4; i++) chk("t3_grant_order", grant_log[i], exp_order[i]);
    end
    chk("t3_result", last_res, 32'h00F0_00F0);

    // Response backpressure
    bus.rsp0_ready = 0;
    send(0, 32'd5, 32'd5, ALU_SUB, w);
    bus.req1_valid = 1; bus.req1_a = 32'd1; bus.req1_b = 32'd2; bus.req1_ctrl = ALU_ADD;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.rsp0_valid && n < 20);
    for (int i = 0; i < 4; i++) begin
      chk("t4_rsp0_valid", bus.rsp0_valid, 1);
      chk("t4_req1_ready", bus.req1_ready, 0);
      chk("t4_result", bus.rsp_result, 0);
      chk("t4_flag_z", bus.rsp_flags[FLAG_Z], 1);
      chk("t4_flag_c", bus.rsp_flags[FLAG_C], 1);
      @(negedge clk);
    end
    @(posedge clk); #1; bus.rsp0_ready = 1;
    @(negedge clk);
    chk("t4_release_req1_ready", bus.req1_ready, 0);
    tick();
    @(negedge clk);
    chk("t4_idle_busy", busy, 0);
    chk("t4_req1_granted", bus.req1_ready, 1);
    tick(); bus.req1_valid = 0;
    drain("t4_drain");
    chk("t4_req1_result", last_res, 32'd3);

    // Overflow
    send(0, 32'h7FFF_FFFF, 32'd1, ALU_ADD, w);
    drain("t5_drain");
    chk("t5_result", last_res, 32'h8000_0000);
    chk("t5_flags", last_flags, 4'b1001);

    // Reset during EXEC
    base = rsp_count;
    send(0, 32'd10, 32'd20, ALU_ADD, w);
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_rsp0_valid", bus.rsp0_valid, 0);
    chk("t6_rsp1_valid", bus.rsp1_valid, 0);
    tick();
    bus.req0_valid = 1; bus.req0_a = 32'd7; bus.req0_b = 32'd1; bus.req0_ctrl = ALU_SUB;
    bus.req1_valid = 1; bus.req1_a = 32'd3; bus.req1_b = 32'd6; bus.req1_ctrl = ALU_ORR;
    @(negedge clk);
    chk("t6_first_grant0", bus.req0_ready, 1);
    chk("t6_first_grant1", bus.req1_ready, 0);
    tick(); bus.req0_valid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.req1_ready && n < 50);
    tick(); bus.req1_valid = 0;
    drain("t6_drain");
    chk("t6_rsp_count", rsp_count - base, 2);

    // Randomized traffic with random response backpressure
    base = rsp_count;
    d0 = 0; d1 = 0;
    fork
      begin
        int wl;
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom % 3) tick();
          send(0, rnd_val(), rnd_val(), 2'($urandom % 4), wl);
        end
        d0 = 1;
      end
      begin
        int wl;
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom % 3) tick();
          send(1, rnd_val(), rnd_val(), 2'($urandom % 4), wl);
        end
        d1 = 1;
      end
      begin
        while (!(d0 && d1)) begin
          tick();
          bus.rsp0_ready = ($urandom % 4) != 0;
          bus.rsp1_ready = ($urandom % 4) != 0;
        end
      end
    join
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    drain("rand_drain");
    chk("rand_rsp_count", rsp_count - base, 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
